sqrt_control: RTL

SQRT_CONTROL -- requirements
Module: sqrt_control

---
 rtl/sqrt_pkg.sv | 43 ++++
 rtl/sqrt_control_reg.sv | 20 ++
 rtl/sqrt_control.sv | 104 ++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// Shared encoding and defaults for the square-root sequencer.
// Strobe decode lives here so every user sees one state-to-strobe map.
package sqrt_pkg;

    localparam int DEF_MAX_ITER = 256;
    localparam int DEF_W_VAL    = 16;
    localparam int DEF_W_ROOT   = 8;
    localparam int ITER_W       = 9;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_INIT = 3'd1;
    localparam state_t S_CMP  = 3'd2;
    localparam state_t S_INC  = 3'd3;
    localparam state_t S_SQ   = 3'd4;
    localparam state_t S_DONE = 3'd5;

    typedef struct packed {
        logic boot;
        logic wr_square;
        logic wr_root;
        logic muxes;
    } strobe_t;

    function automatic strobe_t decode_strobes(input state_t s);
        strobe_t st;
        st = '0;
        case (s)
            S_INIT: begin
                st.boot      = 1'b1;
                st.wr_square = 1'b1;
                st.wr_root   = 1'b1;
            end
            S_CMP:   st.muxes     = 1'b1;
            S_INC:   st.wr_root   = 1'b1;
            S_SQ:    st.wr_square = 1'b1;
            default: st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sqrt_control_reg.sv
// Generic enabled register with async active-low clear, shared by the
// operand latch and the result capture.
module sqrt_control_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/sqrt_control.sv
// Sequencer for an iterative square-root datapath: walks root upward until
// the datapath flags valor < (root+1)^2, or the iteration budget runs out.
//
// state | meaning
// IDLE  | ready for an operand
// INIT  | load datapath init values
// CMP   | compare valor against square
// INC   | root <= root + 1
// SQ    | square <= next square, count one iteration
// DONE  | result held until downstream accepts
module sqrt_control
    import sqrt_pkg::*;
#(
    parameter int MAX_ITER = DEF_MAX_ITER,
    parameter int W_VAL    = DEF_W_VAL,
    parameter int W_ROOT   = DEF_W_ROOT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [W_VAL-1:0]  valor_i,
    output logic [W_VAL-1:0]  valor_o,
    output logic              boot_o,
    output logic              wr_square_o,
    output logic              wr_root_o,
    output logic              muxes_o,
    input  logic              N_i,
    input  logic [W_ROOT-1:0] root_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [W_ROOT-1:0] root_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              ovf_o
);

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

    state_t              state, state_nxt;
    logic [ITER_W-1:0]   iter_cnt;
    logic                accept, at_last, cmp_done;
    strobe_t             stb;

    assign accept   = (state == S_IDLE) && in_valid_i;
    assign at_last  = (iter_cnt == ITER_LAST);
    assign cmp_done = (state == S_CMP) && (N_i || at_last);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid_i) state_nxt = S_INIT;
            S_INIT:  state_nxt = S_CMP;
            S_CMP:   state_nxt = cmp_done ? S_DONE : S_INC;
            S_INC:   state_nxt = S_SQ;
            S_SQ:    state_nxt = S_CMP;
            S_DONE:  if (out_ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Saturating guard is redundant with the CMP exit, but keeps the count
    // safe if the FSM is ever extended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            iter_cnt <= '0;
        else if (accept)
            iter_cnt <= '0;
        else if (state == S_SQ && !at_last)
            iter_cnt <= iter_cnt + 1'b1;
    end

    sqrt_control_reg #(.W(W_VAL)) u_valor_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .d     (valor_i),
        .q     (valor_o)
    );

    // ovf is set only when the budget, not the datapath, ended the loop.
    sqrt_control_reg #(.W(W_ROOT + ITER_W + 1)) u_result_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cmp_done),
        .d     ({!N_i, iter_cnt, root_i}),
        .q     ({ovf_o, iter_o, root_o})
    );

    assign stb         = decode_strobes(state);
    assign boot_o      = stb.boot;
    assign wr_square_o = stb.wr_square;
    assign wr_root_o   = stb.wr_root;
    assign muxes_o     = stb.muxes;
    assign in_ready_o  = (state == S_IDLE);
    assign out_valid_o = (state == S_DONE);

endmodule
